lane_accumulator: RTL

LANE_ACCUMULATOR -- requirements
Module: lane_accumulator

---
 rtl/convnet_pkg.sv | 16 +
 rtl/lane_acc.sv | 47 ++++
 rtl/lane_accumulator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/convnet_pkg.sv
// Shared sizing for the convnet lane datapath.
// The defaults here are the single source for the lane-accumulator geometry.
package convnet_pkg;

    localparam int NUM_LANES = 16;
    localparam int DATA_W    = 32;
    localparam int ACC_STEPS = 4;

    // A one-step group still needs a one-bit counter so the port widths stay legal.
    function automatic int stepWidth(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    localparam int STEP_W = stepWidth(ACC_STEPS);

endpackage

// File: rtl/lane_acc.sv
// One lane of the group accumulator: adder, running sum, group result register
// and signed-overflow detect for the addition performed on the current beat.
module lane_acc
    import convnet_pkg::*;
#(
    parameter int DATA_W = convnet_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_beat,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_out,
    output logic              o_overflow
);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] w_addend;
    logic [DATA_W-1:0] w_sum;

    // A first beat adds to zero, so it loads the input and can never overflow.
    always_comb begin
        w_addend   = i_first ? '0 : r_acc;
        w_sum      = w_addend + i_data;
        o_overflow = (w_addend[DATA_W-1] == i_data[DATA_W-1]) &&
                     (w_sum[DATA_W-1] != w_addend[DATA_W-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (i_beat) begin
            if (i_last) begin
                r_out <= w_sum;
                r_acc <= '0;
            end else begin
                r_acc <= w_sum;
            end
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/lane_accumulator.sv
// Sums ACC_STEPS beats of rotated crossbar data per lane and presents each
// group sum with a one-cycle valid pulse and a group overflow flag.
module lane_accumulator
    import convnet_pkg::*;
#(
    parameter int NUM_LANES = convnet_pkg::NUM_LANES,
    parameter int DATA_W    = convnet_pkg::DATA_W,
    parameter int ACC_STEPS = convnet_pkg::ACC_STEPS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_clk_en,
    input  logic              io_start,
    input  logic [DATA_W-1:0] io_in_0,
    input  logic [DATA_W-1:0] io_in_1,
    input  logic [DATA_W-1:0] io_in_2,
    input  logic [DATA_W-1:0] io_in_3,
    input  logic [DATA_W-1:0] io_in_4,
    input  logic [DATA_W-1:0] io_in_5,
    input  logic [DATA_W-1:0] io_in_6,
    input  logic [DATA_W-1:0] io_in_7,
    input  logic [DATA_W-1:0] io_in_8,
    input  logic [DATA_W-1:0] io_in_9,
    input  logic [DATA_W-1:0] io_in_10,
    input  logic [DATA_W-1:0] io_in_11,
    input  logic [DATA_W-1:0] io_in_12,
    input  logic [DATA_W-1:0] io_in_13,
    input  logic [DATA_W-1:0] io_in_14,
    input  logic [DATA_W-1:0] io_in_15,
    output logic [DATA_W-1:0] io_out_0,
    output logic [DATA_W-1:0] io_out_1,
    output logic [DATA_W-1:0] io_out_2,
    output logic [DATA_W-1:0] io_out_3,
    output logic [DATA_W-1:0] io_out_4,
    output logic [DATA_W-1:0] io_out_5,
    output logic [DATA_W-1:0] io_out_6,
    output logic [DATA_W-1:0] io_out_7,
    output logic [DATA_W-1:0] io_out_8,
    output logic [DATA_W-1:0] io_out_9,
    output logic [DATA_W-1:0] io_out_10,
    output logic [DATA_W-1:0] io_out_11,
    output logic [DATA_W-1:0] io_out_12,
    output logic [DATA_W-1:0] io_out_13,
    output logic [DATA_W-1:0] io_out_14,
    output logic [DATA_W-1:0] io_out_15,
    output logic              io_valid,
    output logic              io_overflow,
    output logic              io_start_next_stage
);

    localparam int STEP_W = stepWidth(ACC_STEPS);

    logic [DATA_W-1:0] w_in  [NUM_LANES];
    logic [DATA_W-1:0] w_out [NUM_LANES];
    logic [NUM_LANES-1:0] w_laneOvf;

    logic [STEP_W-1:0] r_step;
    logic              r_valid;
    logic              r_ovfSticky;
    logic              r_overflow;
    logic              r_startNext;

    logic w_beat;
    logic w_first;
    logic w_last;
    logic w_groupOvf;

    // The lane ports are a fixed 16-wide bundle matching the upstream crossbar.
    assign w_in[0]  = io_in_0;
    assign w_in[1]  = io_in_1;
    assign w_in[2]  = io_in_2;
    assign w_in[3]  = io_in_3;
    assign w_in[4]  = io_in_4;
    assign w_in[5]  = io_in_5;
    assign w_in[6]  = io_in_6;
    assign w_in[7]  = io_in_7;
    assign w_in[8]  = io_in_8;
    assign w_in[9]  = io_in_9;
    assign w_in[10] = io_in_10;
    assign w_in[11] = io_in_11;
    assign w_in[12] = io_in_12;
    assign w_in[13] = io_in_13;
    assign w_in[14] = io_in_14;
    assign w_in[15] = io_in_15;

    assign io_out_0  = w_out[0];
    assign io_out_1  = w_out[1];
    assign io_out_2  = w_out[2];
    assign io_out_3  = w_out[3];
    assign io_out_4  = w_out[4];
    assign io_out_5  = w_out[5];
    assign io_out_6  = w_out[6];
    assign io_out_7  = w_out[7];
    assign io_out_8  = w_out[8];
    assign io_out_9  = w_out[9];
    assign io_out_10 = w_out[10];
    assign io_out_11 = w_out[11];
    assign io_out_12 = w_out[12];
    assign io_out_13 = w_out[13];
    assign io_out_14 = w_out[14];
    assign io_out_15 = w_out[15];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_acc #(
            .DATA_W(DATA_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .i_beat    (w_beat),
            .i_first   (w_first),
            .i_last    (w_last),
            .i_data    (w_in[g]),
            .o_out     (w_out[g]),
            .o_overflow(w_laneOvf[g])
        );
    end

    // With a single step the counter stays at zero, so every beat is both first and last.
    always_comb begin
        w_beat     = io_clk_en & io_start;
        w_first    = (r_step == '0);
        w_last     = (r_step == STEP_W'(ACC_STEPS - 1));
        w_groupOvf = (w_first ? 1'b0 : r_ovfSticky) | (|w_laneOvf);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step      <= '0;
            r_valid     <= 1'b0;
            r_ovfSticky <= 1'b0;
            r_overflow  <= 1'b0;
            r_startNext <= 1'b0;
        end else begin
            r_valid <= w_beat & w_last;
            if (w_beat) begin
                r_step      <= w_last ? '0 : r_step + 1'b1;
                r_ovfSticky <= w_groupOvf;
                if (w_last) begin
                    r_overflow  <= w_groupOvf;
                    r_startNext <= 1'b1;
                end
            end
        end
    end

    assign io_valid            = r_valid;
    assign io_overflow         = r_overflow;
    assign io_start_next_stage = r_startNext;

endmodule
